// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing constants and types for the FIFO controller.
//               DEPTH is derived from ADDR_W so the two can never disagree.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 6;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int AF_THRESH = 60;
    localparam int AE_THRESH = 4;

    // Accepted transfers for one cycle; both may be set together.
    typedef struct packed {
        logic wr_acc;
        logic rd_acc;
    } xfer_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Enable-driven ADDR_W-bit pointer with synchronous reset.
//               Wraps from 2^ADDR_W-1 back to 0 by natural truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
    parameter int ADDR_W = fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] c_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_ptr;

    // Advance one slot per accepted operation; the add overflows back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= r_ptr + c_ONE;
        end
    end

    assign ptr = r_ptr;

endmodule : fifo_ptr
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : Controller for a FIFO built around an external dual-port
//               memory (port A write, port B registered read). Tracks
//               occupancy, produces flags, sticky error bits and a one-cycle
//               read-data valid strobe aligned with the memory read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int DATA_W    = fifo_pkg::DATA_W,
    parameter int ADDR_W    = fifo_pkg::ADDR_W,
    parameter int AF_THRESH = fifo_pkg::AF_THRESH,
    parameter int AE_THRESH = fifo_pkg::AE_THRESH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic [DATA_W-1:0] mem_data_a,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic              mem_we_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic              mem_we_b,
    input  logic [DATA_W-1:0] mem_q_b
);

    import fifo_pkg::*;

    // Occupancy constants sized to the count register so compares are exact.
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] c_AF    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_AE    = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   r_count;
    logic              r_valid;
    logic              r_ovf;
    logic              r_unf;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic              w_full;
    logic              w_empty;
    xfer_t             w_xfer;

    // Flags come straight from the registered count.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Acceptance uses the current count only: no pass-through when full,
    // no bypass when empty, so port A and port B never hit the same word.
    always_comb begin
        w_xfer        = '0;
        w_xfer.wr_acc = push & ~w_full  & ~reset;
        w_xfer.rd_acc = pop  & ~w_empty & ~reset;
    end

    fifo_ptr #(
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (w_xfer.wr_acc),
        .ptr   (w_wr_ptr)
    );

    fifo_ptr #(
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (w_xfer.rd_acc),
        .ptr   (w_rd_ptr)
    );

    // Occupancy: +1 on write only, -1 on read only, hold on both or neither.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_xfer.wr_acc, w_xfer.rd_acc})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Valid strobe trails the accepted read by the memory's one-cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_xfer.rd_acc;
        end
    end

    // Sticky error bits record any request made against the wrong flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (push && w_full) begin
                r_ovf <= 1'b1;
            end
            if (pop && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign mem_we_a      = w_xfer.wr_acc;
    assign mem_addr_a    = w_wr_ptr;
    assign mem_data_a    = data_in;
    assign mem_addr_b    = w_rd_ptr;
    assign mem_we_b      = 1'b0;

    assign data_out      = mem_q_b;
    assign valid_out     = r_valid;
    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;
    assign almost_full   = (r_count >= c_AF);
    assign almost_empty  = (r_count <= c_AE);
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Scoreboard bench for fifo_ctrl with an attached dual-port
//               memory model and a queue-based reference FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [7:0] data_in;
    logic       pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] count;
    logic       overflow_err;
    logic       underflow_err;
    logic [7:0] mem_data_a;
    logic [5:0] mem_addr_a;
    logic       mem_we_a;
    logic [5:0] mem_addr_b;
    logic       mem_we_b;
    logic [7:0] mem_q_b;

    int checks = 0;
    int errors = 0;

    fifo_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .pop           (pop),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .count         (count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .mem_data_a    (mem_data_a),
        .mem_addr_a    (mem_addr_a),
        .mem_we_a      (mem_we_a),
        .mem_addr_b    (mem_addr_b),
        .mem_we_b      (mem_we_b),
        .mem_q_b       (mem_q_b)
    );

    always #5 clk = ~clk;

    // Dual-port memory: port A write, port B registered read.
    logic [7:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem_q_b = 8'h00;
    end
    always @(posedge clk) begin
        if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
        mem_q_b <= mem[mem_addr_b];
    end

    // Reference model: contents as a queue, pointers as plain slot numbers.
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int  wp, rp;
    bit  ovf, unf, exp_valid;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every valid_out beat consumes the oldest expected word.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL data_out unexpected valid actual=%0h expected=none", data_out);
            end else begin
                chk("data_out", data_out, sb.pop_front());
            end
        end
    end

    // One cycle: apply inputs, check combinational/registered view, advance model.
    task automatic step(input bit p, input bit q, input logic [7:0] d, input bit r);
        int  n;
        bit  we, wa, ra;
        push = p; pop = q; data_in = d; reset = r;
        @(negedge clk);
        n  = mq.size();
        we = !r && p && (n < 64);
        chk("mem_we_a", mem_we_a, we);
        if (we) begin
            chk("mem_addr_a", mem_addr_a, wp);
            chk("mem_data_a", mem_data_a, d);
        end
        chk("mem_we_b", mem_we_b, 0);
        chk("mem_addr_b", mem_addr_b, rp);
        chk("count", count, n);
        chk("empty", empty, n == 0);
        chk("full", full, n == 64);
        chk("almost_full", almost_full, n >= 60);
        chk("almost_empty", almost_empty, n <= 4);
        chk("overflow_err", overflow_err, ovf);
        chk("underflow_err", underflow_err, unf);
        chk("valid_out", valid_out, exp_valid);
        @(posedge clk);
        if (r) begin
            mq.delete();
            wp = 0; rp = 0; ovf = 0; unf = 0; exp_valid = 0;
        end else begin
            wa = p && (n < 64);
            ra = q && (n > 0);
            if (p && n == 64) ovf = 1;
            if (q && n == 0)  unf = 1;
            exp_valid = ra;
            if (ra) begin
                sb.push_back(mq.pop_front());
                rp = (rp + 1) % 64;
            end
            if (wa) begin
                mq.push_back(d);
                wp = (wp + 1) % 64;
            end
        end
        #1;
    endtask

    initial begin
        int pw, pr;
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        wp = 0; rp = 0; ovf = 0; unf = 0; exp_valid = 0;

        // Single push then pop of 0xF0
        step(1, 0, 8'hF0, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Fill to full, then one overflowing push, then drain
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 64; i++) step(1, 0, 8'($urandom), 0);
        step(1, 0, 8'hAA, 0);
        for (int i = 0; i < 64; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Pop while empty
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Simultaneous push/pop at count 10
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom), 0);
        step(1, 1, 8'h5A, 0);
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // 100 interleaved pushes/pops of an incrementing pattern (pointer wrap)
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 100; i++) step(1, i > 0, 8'(i), 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // Reset mid-operation at count 30 with overflow_err set
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 64; i++) step(1, 0, 8'($urandom), 0);
        step(1, 0, 8'h11, 0);
        for (int i = 0; i < 34; i++) step(0, 1, 8'h00, 0);
        step(1, 0, 8'h22, 1);
        step(0, 0, 8'h00, 0);

        // Randomized traffic with shifting push/pop bias and rare resets
        pw = 50; pr = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                pw = 10 + 10 * int'($urandom_range(0, 8));
                pr = 10 + 10 * int'($urandom_range(0, 8));
            end
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                 8'($urandom), $urandom_range(0, 399) == 0);
        end

        // Drain and confirm nothing left outstanding
        for (int i = 0; i < 66; i++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_ctrl
`default_nettype wire

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width of the memory words.
REQ-002 SHALL have parameter ADDR_W, default 6, memory address width (depth 2^ADDR_W = 64).
REQ-003 SHALL have parameter AF_THRESH, default 60, almost_full threshold in words.
REQ-004 SHALL have parameter AE_THRESH, default 4, almost_empty threshold in words.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-007 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-008 SHALL have port push, input, 1, the upstream write request.
REQ-009 SHALL have port data_in, input, DATA_W, the upstream write data.
REQ-010 SHALL have port pop, input, 1, the downstream read request.
REQ-011 SHALL have port data_out, output, DATA_W, the read data (equal to mem_q_b).
REQ-012 SHALL have port valid_out, output, 1, which marks data_out valid.
REQ-013 SHALL have ports full, empty, almost_full and almost_empty, output, 1 each, the occupancy flags.
REQ-014 SHALL have port count, output, ADDR_W+1, the number of stored words (0..64).
REQ-015 SHALL have ports overflow_err and underflow_err, output, 1 each, the sticky error flags.
REQ-016 SHALL have ports mem_data_a (output, DATA_W), mem_addr_a (output, ADDR_W) and mem_we_a (output, 1), which drive write port A of the dual-port memory.
REQ-017 SHALL have ports mem_addr_b (output, ADDR_W) and mem_we_b (output, 1), which drive read port B of the dual-port memory; mem_we_b is tied to 0.
REQ-018 SHALL have port mem_q_b, input, DATA_W, the registered read data from memory port B.

Function
REQ-019 SHALL accept a push when push=1 and full=0 (wr_acc), evaluated against the current-cycle count.
REQ-020 SHALL accept a pop when pop=1 and empty=0 (rd_acc), evaluated against the current-cycle count.
REQ-021 SHALL drive mem_we_a=wr_acc, mem_addr_a=wr_ptr and mem_data_a=data_in combinationally in the same cycle.
REQ-022 SHALL drive mem_addr_b=rd_ptr combinationally; the memory returns mem_q_b one clock later.
REQ-023 SHALL assert valid_out for exactly one cycle, one clock after each rd_acc; data_out is then the popped word.
REQ-024 SHALL increment wr_ptr and rd_ptr modulo 64 on their accepted operation (63 -> 0 wrap).
REQ-025 SHALL update count +1 on wr_acc only, -1 on rd_acc only, and leave it unchanged when both are accepted in the same cycle.
REQ-026 SHALL reject a push while full, even if a pop is accepted in the same cycle (no pass-through).
REQ-027 SHALL reject a pop while empty, even if a push is accepted in the same cycle (no bypass); a same-address read/write collision therefore never occurs.
REQ-028 SHALL drive the flags combinationally from the registered count: empty=(count==0), full=(count==64), almost_full=(count>=AF_THRESH), almost_empty=(count<=AE_THRESH).
REQ-029 SHALL set overflow_err on push=1 while full=1, and underflow_err on pop=1 while empty=1; both stay set until reset.
REQ-030 SHALL leave pointers, count and memory untouched on a rejected request.

Reset
REQ-031 SHALL, with reset=1 at a rising clk edge, clear wr_ptr, rd_ptr, count, valid_out, overflow_err and underflow_err to 0.
REQ-032 SHALL give post-reset outputs empty=1, almost_empty=1, full=0, almost_full=0, mem_we_a=0.
REQ-033 SHALL hold mem_we_a=0 and ignore push/pop while reset=1; a reset in mid-operation discards stored contents logically, and the memory itself is not cleared.

Structure
REQ-034 SHALL place DATA_W, ADDR_W, DEPTH=64 and the default thresholds in a shared package fifo_pkg.
REQ-035 SHALL implement each pointer with one sub-module, fifo_ptr (enable-driven wrapping ADDR_W counter with synchronous reset), instantiated twice.

Verification
REQ-036 SHALL cover: reset, push 0xF0 -> mem_we_a=1, mem_addr_a=0, count=1, empty=0; then pop -> mem_addr_b=0, and next cycle valid_out=1 with data_out=0xF0.
REQ-037 SHALL cover: 64 consecutive pushes -> full=1 after the 64th; a 65th push -> mem_we_a=0, count=64, overflow_err=1.
REQ-038 SHALL cover: pop while empty -> valid_out=0 next cycle, count=0, underflow_err=1.
REQ-039 SHALL cover: count=10, push+pop together -> count stays 10 and both pointers advance by 1.
REQ-040 SHALL cover: 100 interleaved push/pop of the incrementing pattern 0x00.. -> pointers wrap 63->0 and data_out order matches push order.
REQ-041 SHALL cover: reset asserted at count=30 with overflow_err set -> next cycle count=0, empty=1, almost_empty=1, overflow_err=0, valid_out=0.
